// File: rtl/fir_ahb_slave.sv
// fir_ahb_slave: AHB-Lite halfword register front end for fir_filter.
// Holds the sample and four coefficients, captures the filter result on
// every falling edge of modwait, and streams F0..F3 into the filter via a
// small loader FSM when the host sets LOAD_CTRL bit0.
module fir_ahb_slave (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hsel,
  input  logic [3:0]  haddr,
  input  logic        hsize,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [15:0] hwdata,
  output logic [15:0] hrdata,
  output logic        hresp,
  input  logic        modwait,
  input  logic [15:0] fir_out,
  input  logic        err,
  output logic [15:0] sample_data,
  output logic        data_ready,
  output logic [15:0] fir_coefficient,
  output logic        load_coeff
);

  // Halfword register slots, indexed by haddr[3:1].
  typedef enum logic [2:0] {
    REG_STATUS = 3'd0,
    REG_RESULT = 3'd1,
    REG_SAMPLE = 3'd2,
    REG_F0     = 3'd3,
    REG_F1     = 3'd4,
    REG_F2     = 3'd5,
    REG_F3     = 3'd6,
    REG_LDCTRL = 3'd7
  } reg_e;

  // Loader phase; the coefficient index k is kept in a separate counter.
  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_LOAD    = 2'd1,
    L_WAIT_HI = 2'd2,
    L_WAIT_LO = 2'd3
  } ld_phase_e;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Merge a write into an existing halfword: full halfword or one byte lane.
  function automatic logic [15:0] merge_lane(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic        full,
                                             input logic        upper);
    if (full)       return new_val;
    else if (upper) return {new_val[15:8], old_val[7:0]};
    else            return {old_val[15:8], new_val[7:0]};
  endfunction

  // Data-phase copy of the address phase
  logic       dp_valid_q, dp_valid_d;
  logic       dp_write_q, dp_write_d;
  logic       dp_size_q,  dp_size_d;
  logic [3:0] dp_addr_q,  dp_addr_d;

  // Register file and filter-side state
  logic [15:0] sample_q, sample_d;
  logic [15:0] coef_q [4];
  logic [15:0] coef_d [4];
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic        load_req_q, load_req_d;
  logic        modwait_q;
  logic        sample_pend_q, sample_pend_d;
  logic        data_ready_q, data_ready_d;

  // Loader FSM
  ld_phase_e   ld_phase_q, ld_phase_d;
  logic [1:0]  ld_idx_q, ld_idx_d;
  logic        loader_busy;
  logic        load_go;
  logic        load_done;

  // Decoded data-phase signals
  reg_e        reg_sel;
  logic        dp_wr;
  logic        dp_rd;
  logic        busy;
  logic        modwait_fall;
  logic [15:0] rd_val;
  logic [15:0] wr_val;
  logic        sample_req;
  logic        sample_rel;

  // Capture the address phase of every active transfer.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    dp_valid_d = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_addr_d  = dp_addr_q;
    if (dp_valid_d) begin
      dp_write_d = hwrite;
      dp_size_d  = hsize;
      dp_addr_d  = haddr;
    end
  end

  // Address-phase pipeline register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_size_q  <= 1'b0;
      dp_addr_q  <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_size_q  <= dp_size_d;
      dp_addr_q  <= dp_addr_d;
    end
  end

  assign reg_sel      = reg_e'(dp_addr_q[3:1]);
  assign dp_wr        = dp_valid_q && dp_write_q;
  assign dp_rd        = dp_valid_q && !dp_write_q;
  assign busy         = modwait || data_ready_q || loader_busy;
  assign modwait_fall = modwait_q && !modwait;
  assign load_done    = (ld_phase_q == L_WAIT_LO) && (ld_idx_q == 2'd3) && !modwait;

  // Register read mux; also the base value that byte writes merge into.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: rd_val = {7'd0, err_q, 7'd0, busy};
      REG_RESULT: rd_val = result_q;
      REG_SAMPLE: rd_val = sample_q;
      REG_F0:     rd_val = coef_q[0];
      REG_F1:     rd_val = coef_q[1];
      REG_F2:     rd_val = coef_q[2];
      REG_F3:     rd_val = coef_q[3];
      REG_LDCTRL: rd_val = {15'd0, load_req_q || loader_busy};
    endcase
  end

  assign wr_val = merge_lane(rd_val, hwdata, dp_size_q, dp_addr_q[0]);

  // Reads return the full halfword during the data phase; a write that
  // lands in the same register the cycle before is already visible here.
  assign hrdata = dp_rd ? rd_val : '0;
  assign hresp  = dp_wr && ((reg_sel == REG_STATUS) || (reg_sel == REG_RESULT));

  // Register-file next state: bus writes and result capture.
  always_comb begin
    sample_d   = sample_q;
    coef_d     = coef_q;
    result_d   = result_q;
    err_d      = err_q;
    load_req_d = load_req_q;
    if (dp_wr) begin
      case (reg_sel)
        REG_SAMPLE: sample_d  = wr_val;
        REG_F0:     coef_d[0] = wr_val;
        REG_F1:     coef_d[1] = wr_val;
        REG_F2:     coef_d[2] = wr_val;
        REG_F3:     coef_d[3] = wr_val;
        REG_LDCTRL: if (!loader_busy) load_req_d = wr_val[0];
        default:    ;
      endcase
    end
    if (load_done) load_req_d = 1'b0;
    if (modwait_fall) begin
      result_d = fir_out;
      err_d    = err;
    end
  end

  // Sample handshake: a pending sample is released only while the loader
  // is idle and not starting; an overwrite while data_ready is high does
  // not generate a second request.
  always_comb begin
    sample_req    = sample_pend_q || (dp_wr && (reg_sel == REG_SAMPLE) && !data_ready_q);
    sample_rel    = sample_req && !data_ready_q && !loader_busy && !load_go;
    sample_pend_d = sample_req && !sample_rel;
    data_ready_d  = data_ready_q ? !modwait : sample_rel;
  end

  // Register file, capture and handshake state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_q      <= '0;
      // NOTE: the coefficient array is reset element by element because the
      // filter may see fir_coefficient = F0 straight out of reset.
      for (int i = 0; i < 4; i++) coef_q[i] <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      load_req_q    <= 1'b0;
      modwait_q     <= 1'b0;
      sample_pend_q <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      coef_q        <= coef_d;
      result_q      <= result_d;
      err_q         <= err_d;
      load_req_q    <= load_req_d;
      modwait_q     <= modwait;
      sample_pend_q <= sample_pend_d;
      data_ready_q  <= data_ready_d;
    end
  end

  // Loader state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ld_phase_q <= L_IDLE;
      ld_idx_q   <= 2'd0;
    end else begin
      ld_phase_q <= ld_phase_d;
      ld_idx_q   <= ld_idx_d;
    end
  end

  // Loader next state: one LOAD cycle per coefficient, then a full
  // modwait rise/fall before the next one.
  always_comb begin
    ld_phase_d = ld_phase_q;
    ld_idx_d   = ld_idx_q;
    load_go    = 1'b0;
    case (ld_phase_q)
      L_IDLE: begin
        load_go = load_req_d && !data_ready_q;
        if (load_go) begin
          ld_phase_d = L_LOAD;
          ld_idx_d   = 2'd0;
        end
      end
      L_LOAD:    ld_phase_d = L_WAIT_HI;
      L_WAIT_HI: if (modwait) ld_phase_d = L_WAIT_LO;
      L_WAIT_LO: begin
        if (!modwait) begin
          if (ld_idx_q == 2'd3) begin
            ld_phase_d = L_IDLE;
            ld_idx_d   = 2'd0;
          end else begin
            ld_phase_d = L_LOAD;
            ld_idx_d   = ld_idx_q + 2'd1;
          end
        end
      end
    endcase
  end

  // Loader outputs: strobe in LOAD, coefficient follows the current index.
  always_comb begin
    loader_busy     = (ld_phase_q != L_IDLE);
    load_coeff      = (ld_phase_q == L_LOAD);
    fir_coefficient = loader_busy ? coef_q[ld_idx_q] : coef_q[0];
  end

  assign sample_data = sample_q;
  assign data_ready  = data_ready_q;

endmodule

// File: tb/tb_fir_ahb_slave.sv
// tb_fir_ahb_slave: directed and randomized bench for fir_ahb_slave with a
// behavioural fir_filter stand-in that answers data_ready / load_coeff by
// raising modwait for a programmable time.
module tb_fir_ahb_slave;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel;
  logic [3:0]  haddr;
  logic        hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;
  logic        modwait = 1'b0;
  logic [15:0] fir_out = 16'h0000;
  logic        err = 1'b0;
  logic [15:0] sample_data;
  logic        data_ready;
  logic [15:0] fir_coefficient;
  logic        load_coeff;

  fir_ahb_slave dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .hsel            (hsel),
    .haddr           (haddr),
    .hsize           (hsize),
    .htrans          (htrans),
    .hwrite          (hwrite),
    .hwdata          (hwdata),
    .hrdata          (hrdata),
    .hresp           (hresp),
    .modwait         (modwait),
    .fir_out         (fir_out),
    .err             (err),
    .sample_data     (sample_data),
    .data_ready      (data_ready),
    .fir_coefficient (fir_coefficient),
    .load_coeff      (load_coeff)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Filter stand-in configuration (written by the stimulus only).
  int          fm_rise = 1;
  int          fm_hold = 2;
  logic [15:0] fm_out  = 16'h0000;
  logic        fm_err  = 1'b0;

  // Filter stand-in observations (written by the stand-in only).
  int          m_phase = 0;
  int          m_cnt = 0;
  bit          m_is_sample = 1'b0;
  int          m_done = 0;
  int          lc_cycles = 0;
  logic [15:0] m_result = 16'h0000;
  logic        m_errbit = 1'b0;
  logic [15:0] coef_log [$];

  // Reference register contents.
  logic [15:0] ref_coef [4];
  logic [15:0] ref_sample;

  // Filter stand-in: accept a request, raise modwait after fm_rise cycles,
  // hold it fm_hold cycles, then drop it with the result on fir_out.
  always @(negedge clk) begin
    if (!n_rst) begin
      m_phase  = 0;
      m_cnt    = 0;
      modwait  = 1'b0;
      m_result = 16'h0000;
      m_errbit = 1'b0;
    end else begin
      if (load_coeff) lc_cycles++;
      case (m_phase)
        0: if (load_coeff || data_ready) begin
             m_is_sample = !load_coeff;
             if (load_coeff) coef_log.push_back(fir_coefficient);
             m_cnt   = fm_rise;
             m_phase = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) begin
               modwait = 1'b1;
               m_cnt   = fm_hold;
               m_phase = 2;
             end
           end
        default: begin
             m_cnt--;
             if (m_cnt == 0) begin
               modwait = 1'b0;
               if (m_is_sample) begin
                 fir_out = fm_out;
                 err     = fm_err;
               end
               m_result = fir_out;
               m_errbit = err;
               m_done++;
               m_phase  = 0;
             end
           end
      endcase
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [15:0] d, input logic sz,
                           output logic resp);
    @(negedge clk);
    hsel = 1'b1; haddr = a; hsize = sz; hwrite = 1'b1; htrans = 2'b10;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    #1 resp = hresp;
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    hsel = 1'b1; haddr = a; hsize = 1'b1; hwrite = 1'b0; htrans = 2'b10;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    #1 d = hrdata;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] v;
    ahb_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic wr_check(input string tag, input logic [3:0] a, input logic [15:0] d,
                          input logic sz, input logic exp_resp);
    logic r;
    ahb_write(a, d, sz, r);
    check(tag, 16'(r), 16'(exp_resp));
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && m_done < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("wait_done", 16'(m_done >= target), 16'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_sample(input logic [15:0] d, input logic [15:0] o, input logic e);
    int target;
    fm_out = o;
    fm_err = e;
    target = m_done + 1;
    wr_check("sample_wr_resp", 4'h4, d, 1'b1, 1'b0);
    ref_sample = d;
    wait_done(target);
  endtask

  task automatic do_load();
    int base_lc;
    int base_q;
    int target;
    base_lc = lc_cycles;
    base_q  = coef_log.size();
    target  = m_done + 4;
    wr_check("load_wr_resp", 4'hE, 16'h0001, 1'b1, 1'b0);
    wait_done(target);
    check("load_pulses", 16'(lc_cycles - base_lc), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (coef_log.size() > base_q + i) check("load_coef", coef_log[base_q + i], ref_coef[i]);
      else check("load_coef_missing", 16'(coef_log.size()), 16'(base_q + 4));
    end
    rd_check("ldctrl_clear", 4'hE, 16'h0000);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_hrdata"}, hrdata, 16'h0000);
    check({tag, "_hresp"}, 16'(hresp), 16'h0000);
    check({tag, "_data_ready"}, 16'(data_ready), 16'h0000);
    check({tag, "_load_coeff"}, 16'(load_coeff), 16'h0000);
    check({tag, "_sample_data"}, sample_data, 16'h0000);
    check({tag, "_fir_coef"}, fir_coefficient, 16'h0000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [15:0] d;
    logic [15:0] o;
    logic [7:0]  b;
    logic        e;
    logic        lane;
    int          k;
    int          target;
    int          dr_early;
    int          base_lc;

    n_rst = 1'b0;
    hsel = 1'b0; haddr = 4'h0; hsize = 1'b1; htrans = 2'b00; hwrite = 1'b0; hwdata = 16'h0000;
    for (int i = 0; i < 4; i++) ref_coef[i] = 16'h0000;
    ref_sample = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("por");
    n_rst = 1'b1;
    rd_check("por_status", 4'h0, 16'h0000);
    rd_check("por_result", 4'h2, 16'h0000);
    rd_check("por_ldctrl", 4'hE, 16'h0000);

    // Coefficient writes, readback and a single-byte write
    for (int i = 0; i < 4; i++) begin
      wr_check("coef_wr_resp", 4'(6 + 2 * i), 16'(i + 1), 1'b1, 1'b0);
      ref_coef[i] = 16'(i + 1);
    end
    for (int i = 0; i < 4; i++) rd_check("coef_rd", 4'(6 + 2 * i), ref_coef[i]);
    wr_check("byte_wr_resp", 4'h9, 16'hABAB, 1'b0, 1'b0);
    ref_coef[1] = 16'hAB02;
    rd_check("byte_f1", 4'h8, 16'hAB02);
    wr_check("byte_lo_resp", 4'hC, 16'h7777, 1'b0, 1'b0);
    ref_coef[3] = 16'h0077;
    rd_check("byte_lo_f3", 4'hC, 16'h0077);

    // Coefficient load with a 2-cycle modwait per coefficient
    fm_rise = 1; fm_hold = 2;
    base_lc = lc_cycles;
    k = coef_log.size();
    target = m_done + 4;
    wr_check("ld_wr_resp", 4'hE, 16'h0001, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("ld_first_pulse", 16'(load_coeff), 16'd1);
    check("ld_first_coef", fir_coefficient, ref_coef[0]);
    @(negedge clk); #1;
    check("ld_pulse_width", 16'(load_coeff), 16'd0);
    rd_check("ld_status_busy", 4'h0, 16'h0001);
    rd_check("ld_ctrl_busy", 4'hE, 16'h0001);
    wait_done(target);
    check("ld_pulses", 16'(lc_cycles - base_lc), 16'd4);
    for (int i = 0; i < 4; i++) check("ld_coef", coef_log[k + i], ref_coef[i]);
    rd_check("ld_ctrl_done", 4'hE, 16'h0000);
    @(negedge clk); #1;
    check("idle_fir_coef", fir_coefficient, ref_coef[0]);

    // Sample handshake
    fm_rise = 1; fm_hold = 5; fm_out = 16'h00AA; fm_err = 1'b0;
    target = m_done + 1;
    wr_check("smp_wr_resp", 4'h4, 16'h1234, 1'b1, 1'b0);
    ref_sample = 16'h1234;
    @(negedge clk); #1;
    check("smp_dr_set", 16'(data_ready), 16'd1);
    check("smp_data", sample_data, 16'h1234);
    for (int i = 0; i < 10 && !modwait; i++) begin
      @(negedge clk); #1;
    end
    check("smp_modwait_up", 16'(modwait), 16'd1);
    @(negedge clk); #1;
    check("smp_dr_cleared", 16'(data_ready), 16'd0);
    wait_done(target);
    rd_check("smp_result", 4'h2, 16'h00AA);
    rd_check("smp_status", 4'h0, 16'h0000);
    rd_check("smp_rd", 4'h4, 16'h1234);

    // Error responses and the live err bit
    wr_check("err_wr_result", 4'h2, 16'hDEAD, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("err_resp_one_cycle", 16'(hresp), 16'd0);
    rd_check("err_result_kept", 4'h2, 16'h00AA);
    wr_check("err_wr_status", 4'h0, 16'hFFFF, 1'b1, 1'b1);
    rd_check("err_status_kept", 4'h0, 16'h0000);
    do_sample(16'h0042, 16'h0F0F, 1'b1);
    rd_check("err_status_set", 4'h0, 16'h0100);
    do_sample(16'h0043, 16'h0F10, 1'b0);
    rd_check("err_status_clr", 4'h0, 16'h0000);
    rd_check("err_result_new", 4'h2, 16'h0F10);

    // SAMPLE write during loading is held off until the loader is idle
    fm_rise = 1; fm_hold = 2; fm_out = 16'h1111; fm_err = 1'b0;
    target = m_done + 4;
    wr_check("col_ld_resp", 4'hE, 16'h0001, 1'b1, 1'b0);
    wr_check("col_smp_resp", 4'h4, 16'h0BEE, 1'b1, 1'b0);
    ref_sample = 16'h0BEE;
    dr_early = 0;
    for (int i = 0; i < 400 && m_done < target; i++) begin
      @(negedge clk); #1;
      if (data_ready) dr_early++;
    end
    check("col_dr_held", 16'(dr_early), 16'd0);
    for (int i = 0; i < 10 && !data_ready; i++) begin
      @(negedge clk); #1;
    end
    check("col_dr_after", 16'(data_ready), 16'd1);
    check("col_smp_data", sample_data, 16'h0BEE);
    wait_done(target + 1);
    rd_check("col_result", 4'h2, 16'h1111);

    // Write immediately followed by a read of the same register
    @(negedge clk);
    hsel = 1'b1; haddr = 4'h8; hsize = 1'b1; hwrite = 1'b1; htrans = 2'b10;
    @(negedge clk);
    hwdata = 16'h5555; haddr = 4'h8; hwrite = 1'b0; htrans = 2'b11;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    #1 check("fwd_rd", hrdata, 16'h5555);
    ref_coef[1] = 16'h5555;

    // Randomized mix against the reference register contents
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          k = $urandom_range(0, 3);
          if ($urandom_range(0, 1) == 1) begin
            d = 16'($urandom);
            wr_check("rnd_hw_resp", 4'(6 + 2 * k), d, 1'b1, 1'b0);
            ref_coef[k] = d;
          end else begin
            b = 8'($urandom);
            lane = 1'($urandom_range(0, 1));
            wr_check("rnd_byte_resp", 4'(6 + 2 * k + int'(lane)), {b, b}, 1'b0, 1'b0);
            if (lane) ref_coef[k] = (ref_coef[k] & 16'h00FF) | (16'(b) << 8);
            else      ref_coef[k] = (ref_coef[k] & 16'hFF00) | 16'(b);
          end
          rd_check("rnd_coef", 4'(6 + 2 * k), ref_coef[k]);
        end
        1: begin
          fm_rise = $urandom_range(1, 3);
          fm_hold = $urandom_range(1, 4);
          d = 16'($urandom);
          o = 16'($urandom);
          e = 1'($urandom_range(0, 1));
          do_sample(d, o, e);
          rd_check("rnd_result", 4'h2, o);
          rd_check("rnd_status", 4'h0, {7'd0, e, 8'd0});
          rd_check("rnd_sample", 4'h4, d);
        end
        default: begin
          fm_rise = $urandom_range(1, 3);
          fm_hold = $urandom_range(1, 4);
          do_load();
        end
      endcase
    end

    // Reset in the middle of a load and a bus transfer
    fm_rise = 1; fm_hold = 6;
    wr_check("rst_ld_resp", 4'hE, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    hsel = 1'b1; haddr = 4'h2; hsize = 1'b1; hwrite = 1'b1; htrans = 2'b10;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 16'hFFFF;
    #1 check("rst_pre_hresp", 16'(hresp), 16'd1);
    #1 n_rst = 1'b0;
    #1 check_outputs_zero("rst");
    base_lc = lc_cycles;
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 4; i++) ref_coef[i] = 16'h0000;
    ref_sample = 16'h0000;
    repeat (40) @(negedge clk);
    check("rst_no_pulses", 16'(lc_cycles - base_lc), 16'd0);
    rd_check("rst_status", 4'h0, 16'h0000);
    rd_check("rst_f0", 4'h6, ref_coef[0]);
    rd_check("rst_ldctrl", 4'hE, 16'h0000);
    rd_check("rst_sample", 4'h4, ref_sample);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_ahb_slave.md
# fir_ahb_slave

AHB-Lite slave front end for `fir_filter`. It gives the bus a halfword register map and drives the filter's sample, coefficient and handshake inputs (`sample_data`, `data_ready`, `fir_coefficient`, `load_coeff`). It captures `fir_out` and `err` for readback. A built-in coefficient-load FSM streams the four stored coefficients into the filter when the host requests it.

## Interface
- No parameters; the widths below are fixed.
- `clk`  in  1  system clock; everything is rising-edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `hsel`  in  1  slave select.
- `haddr`  in  4  byte address.
- `hsize`  in  1  transfer size: 0 = byte, 1 = halfword.
- `htrans`  in  2  transfer type: NONSEQ (2) and SEQ (3) are active; IDLE and BUSY are ignored.
- `hwrite`  in  1  1 = write.
- `hwdata`  in  16  write data, valid in the data phase.
- `hrdata`  out  16  read data, valid in the data phase.
- `hresp`  out  1  error response, one cycle, in the data phase.
- `modwait`  in  1  from the filter: busy.
- `fir_out`  in  16  from the filter: result.
- `err`  in  1  from the filter: overflow or protocol error.
- `sample_data`  out  16  to the filter: current sample register.
- `data_ready`  out  1  to the filter: new sample available.
- `fir_coefficient`  out  16  to the filter: coefficient being loaded.
- `load_coeff`  out  1  to the filter: coefficient strobe.

## Operation
Register map:
- 0x0 STATUS (RO): bit0 = busy, bit8 = err, all other bits 0.
  - busy = `modwait` | `data_ready` | (loader not IDLE).
- 0x2 RESULT (RO): the captured `fir_out`.
- 0x4 SAMPLE (RW): a write sets a pending-sample flag.
- 0x6, 0x8, 0xA, 0xC: coefficients F0, F1, F2, F3 (RW).
- 0xE LOAD_CTRL (RW): bit0 = load request; it reads 1 while loading and self-clears; other bits read 0.

Bus transfers:
- Each active address phase registers `haddr`, `hsize` and `hwrite`. The following cycle is the data phase.
- Halfword write: the whole register is updated from `hwdata`.
- Byte write: only the lane selected by `haddr[0]` is updated (0 → [7:0], 1 → [15:8]).
- Reads always return the full halfword.
- A write to 0x0 or 0x2 asserts `hresp` = 1 for the data-phase cycle and modifies nothing.
- A write to LOAD_CTRL while the loader is busy is ignored, without error.
- Write-then-read forwarding: if a data-phase write and the next address-phase read target the same register, `hrdata` in the following cycle returns the newly written value.

Sample handshake:
- The pending-sample flag is released to `data_ready` only when the loader is IDLE. `data_ready` stays 1 until `modwait` is sampled 1, then clears.
- A second SAMPLE write while `data_ready` = 1 overwrites `sample_data`. No second request is generated.
- On every 1→0 transition of `modwait`, RESULT ← `fir_out`, and the err bit ← `err`.
  - The err bit is live: it clears when `err` is 0 at the next capture.

Coefficient loader FSM:
- States: IDLE, LOAD(k), WAIT_HI(k), WAIT_LO(k), for k = 0..3.
- Transitions:
  - IDLE → LOAD(0) when LOAD_CTRL bit0 is written to 1 and `data_ready` = 0.
  - LOAD(k) drives `fir_coefficient` = Fk and `load_coeff` = 1 for exactly one cycle, then goes to WAIT_HI(k).
  - WAIT_HI(k) → WAIT_LO(k) when `modwait` = 1.
  - WAIT_LO(k) → LOAD(k+1) when `modwait` = 0. After k = 3 it goes to IDLE instead, and LOAD_CTRL bit0 clears.
- The Fk value used is the register content at that LOAD cycle. Coefficient writes during loading are accepted.
- A pending sample waits until the FSM returns to IDLE.
- When the FSM is IDLE, `fir_coefficient` = F0.

Reset (`n_rst` = 0, asynchronous):
- All registers and flags → 0; FSM → IDLE.
- Outputs → 0: `hrdata`, `hresp`, `data_ready`, `load_coeff`, `sample_data`, `fir_coefficient`.
- Reset mid-load abandons the sequence; no further `load_coeff` pulses are issued.

## Timing
- Write latency: a data-phase write in cycle N makes the register visible on its outputs in cycle N+1.
- SAMPLE write: `data_ready` = 1 from cycle N+1 when the loader is IDLE.
- `hresp` and `hrdata` are valid in the data-phase cycle. Zero wait states; no `hready` output.
- `load_coeff` pulses exactly one cycle per coefficient, and a new pulse never starts before `modwait` has risen and fallen for the previous one.
- Loader start: LOAD_CTRL write data phase in cycle N → first `load_coeff` in cycle N+1.
- Back-to-back transfers (NONSEQ followed by SEQ with no idle cycle) are fully supported.

## Test plan
- Reset: assert `n_rst` = 0 mid-transfer → all outputs 0 and STATUS reads 0x0000 after release.
- Coefficients: halfword writes 0x6..0xC = 0x0001, 0x0002, 0x0003, 0x0004, then read back; byte write 0xAB to 0x9 → F1 reads 0xAB02.
- Coefficient load: write 0x0001 to 0xE with a filter model that holds `modwait` for 2 cycles per load → exactly four `load_coeff` pulses carrying F0..F3, then 0xE reads 0.
- Sample handshake: write 0x1234 to 0x4; model raises `modwait` 1 cycle later and drops it 5 cycles later with `fir_out` = 0x00AA → `data_ready` clears on `modwait`, RESULT reads 0x00AA, STATUS busy bit returns 0.
- Errors: write to 0x2 → `hresp` = 1 for one cycle and RESULT unchanged; `err` = 1 at capture → STATUS reads 0x0100.
- Collision and forwarding: SAMPLE write during loading → `data_ready` held off until the FSM is IDLE; write 0x5555 to 0x8 immediately followed by a read of 0x8 → 0x5555.
